alu_issue_seq: RTL and testbench
================================

// Module: alu_issue_seq
// PURPOSE
//  Multi-cycle fetch/decode/issue sequencer on the control side of the ALU. Fetches 16-bit
//  instructions from instruction memory, drives register-file read addresses plus ALU op/eq/ltgt,
//  samples ALU out/compres, then performs register writeback and PC update. Sits between imem,
//  regfile and ALU; regfile read data is wired straight to ALU res/register.
// PARAMETERS
//  PC_W      8     program-counter width; PC wraps modulo 2^PC_W
//  RESET_PC  0     PC value loaded on reset
//  C1_ADDR   4'd1  regfile index of $c1 (branch compare, drives ALU res)
//  C2_ADDR   4'd2  regfile index of $c2 (branch compare, drives ALU register)
// PORTS
//  clock         in   1     single clock, rising edge
//  reset         in   1     asynchronous, active-high
//  imem_req      out  1     fetch request; held until imem_ack
//  imem_addr     out  PC_W  fetch address (= pc)
//  imem_ack      in   1     instruction valid this cycle; ignored outside FETCH
//  imem_data     in   16    instruction word
//  rf_raddr_a    out  4     read port A -> ALU res
//  rf_raddr_b    out  4     read port B -> ALU register
//  alu_op        out  4     ALU op code
//  alu_eq        out  1     ALU eq qualifier
//  alu_ltgt      out  3     ALU compare select
//  alu_out       in   16    ALU result
//  alu_compres   in   1     ALU branch-compare result
//  rf_we         out  1     one-cycle write strobe
//  rf_waddr      out  4     write index
//  rf_wdata      out  16    write data
//  pc            out  PC_W  current PC
//  halted        out  1     high in HALT
//  br_taken_cnt  out  16    taken-branch count (see CONFIGURATION)
// BEHAVIOUR
//  Format: [15:12] opc, [11:8] rd, [7:4] ra, [3:0] rb. Branch: [11] eq, [10:9] ltgt, [8:0] signed off.
//  opc 0 ADD : op=0 eq=1, A=ra B=rb, rd<=out     | opc 1 SUB : op=0 eq=0 (never ALU op 1), rd<=out
//  opc 5 EPAR: op=5, A=ra, rd<=out (parity bit)  | opc 4 BR  : op=4, eq/ltgt from instr, A=C1_ADDR B=C2_ADDR
//  opc 15 HALT -> HALT; every other opc = NOP (pc+1, no write). ltgt=3 in BR = never taken.
//  FSM: IDLE -> FETCH -> DECODE -> EXEC -> WB -> FETCH; HALT absorbing until reset.
//   IDLE : all outputs 0; unconditional -> FETCH next cycle.
//   FETCH: imem_req=1, imem_addr=pc; on imem_ack latch imem_data into IR -> DECODE; else stay.
//   DECODE: drive rf_raddr_a/b, alu_op/eq/ltgt from IR (held stable through EXEC).
//   EXEC : ALU settled; register alu_out, alu_compres at end of cycle.
//   WB   : rf_we=1 for ADD/SUB/EPAR only (rd=0 still written); pc <= taken ? pc+sext(off) : pc+1.
//  Latency: 4 cycles/instruction with same-cycle ack; each ack wait adds 1. PC add truncates to PC_W.
//  ALU control outputs 0 outside DECODE/EXEC; rf_we only in WB.
//  Reset (any time, incl. mid-fetch with req high): state=IDLE, pc=RESET_PC, IR=0, all outputs 0,
//   br_taken_cnt=0; req drops asynchronously, in-flight ack discarded.
//  imem_ack while not in FETCH: ignored, no state change.
// CONFIGURATION
//  ALU_ISSUE_BRCNT_EN defined: br_taken_cnt +1 in WB of each taken BR, saturates at 16'hFFFF.
//  Not defined: br_taken_cnt tied 16'h0000, no counter flops; all else identical.
// STRUCTURE
//  Package alu_issue_pkg: opcode constants, ALU op codes (ADD=0, BR=4, EPAR=5), ltgt codes
//   (EQ=0, LE=1, GE=2), FSM state encoding, instruction field offsets.
//  Sub-module alu_issue_decode: combinational IR -> {rf_raddr_a/b, alu_op, alu_eq, alu_ltgt,
//   writes_rd, is_branch, is_halt}; FSM, PC, IR, counter stay in alu_issue_seq.
// TESTING
//  1 reset, ack tied high, imem[0]=16'h0312 (ADD r3,r1,r2), alu_out=16'h0007 -> WB cycle 4: rf_we=1,
//    rf_waddr=3, rf_wdata=7; pc 0->1; alu_op=0 alu_eq=1 in DECODE/EXEC.
//  2 SUB 16'h1312 -> alu_op=0, alu_eq=0; EPAR 16'h5410, alu_out=1 -> rf_waddr=4, rf_wdata=1.
//  3 pc=10, BR 16'h4A05 (eq=1, ltgt=1, off=+5), compres=1 -> rf_raddr_a=1, b=2, alu_ltgt=1, pc=15,
//    no rf_we; same with compres=0 -> pc=11; off=9'h1FF, compres=1 -> pc=9.
//  4 imem_ack low 3 cycles in FETCH -> imem_req held, pc/IR stable; instruction = 7 cycles.
//  5 pc=255 (PC_W=8) NOP -> pc=0; HALT 16'hF000 -> halted=1, imem_req stays 0 for 20 cycles.
//  6 reset pulse in EXEC -> outputs 0, pc=0 immediately; refetch addr 0; with ALU_ISSUE_BRCNT_EN
//    3 taken + 2 not-taken BR -> br_taken_cnt=3; without -> 0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// rtl/alu_issue_pkg.sv - shared constants and types for the ALU issue sequencer
// Purpose: opcode constants, ALU op and compare codes, FSM state encoding and
//          instruction field offsets used by alu_issue_decode and alu_issue_seq.
// Ports:   none (package).
package alu_issue_pkg;

  // Instruction opcodes, field [15:12]
  localparam logic [3:0] OPC_ADD  = 4'd0;
  localparam logic [3:0] OPC_SUB  = 4'd1;
  localparam logic [3:0] OPC_BR   = 4'd4;
  localparam logic [3:0] OPC_EPAR = 4'd5;
  localparam logic [3:0] OPC_HALT = 4'd15;

  // ALU op codes; SUB is issued as op ADD with eq=0, ALU op 1 is never used
  localparam logic [3:0] ALU_OP_ADD  = 4'd0;
  localparam logic [3:0] ALU_OP_BR   = 4'd4;
  localparam logic [3:0] ALU_OP_EPAR = 4'd5;

  // ALU compare select codes; NEVER marks a branch that can not be taken
  localparam logic [2:0] LTGT_EQ    = 3'd0;
  localparam logic [2:0] LTGT_LE    = 3'd1;
  localparam logic [2:0] LTGT_GE    = 3'd2;
  localparam logic [1:0] LTGT_NEVER = 2'd3;

  // Instruction field offsets
  localparam int OPC_LSB     = 12;
  localparam int RD_LSB      = 8;
  localparam int RA_LSB      = 4;
  localparam int RB_LSB      = 0;
  localparam int BR_EQ_BIT   = 11;
  localparam int BR_LTGT_LSB = 9;
  localparam int BR_OFF_W    = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - imem / regfile / ALU bus bundle for the issue sequencer
// Purpose: groups the instruction fetch handshake, register-file ports and ALU
//          control/result signals.
// Ports:   master = sequencer side (drives req/addr, rf ports, ALU control),
//          slave  = environment side (imem, regfile and ALU).
interface alu_issue_if #(
  parameter int PC_W = 8
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [15:0]     imem_data;
  logic [3:0]      rf_raddr_a;
  logic [3:0]      rf_raddr_b;
  logic [3:0]      alu_op;
  logic            alu_eq;
  logic [2:0]      alu_ltgt;
  logic [15:0]     alu_out;
  logic            alu_compres;
  logic            rf_we;
  logic [3:0]      rf_waddr;
  logic [15:0]     rf_wdata;

  modport master (
    output imem_req, imem_addr, rf_raddr_a, rf_raddr_b,
           alu_op, alu_eq, alu_ltgt, rf_we, rf_waddr, rf_wdata,
    input  imem_ack, imem_data, alu_out, alu_compres
  );

  modport slave (
    input  imem_req, imem_addr, rf_raddr_a, rf_raddr_b,
           alu_op, alu_eq, alu_ltgt, rf_we, rf_waddr, rf_wdata,
    output imem_ack, imem_data, alu_out, alu_compres
  );
endinterface

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational instruction decoder
// Purpose: maps the instruction register to regfile read addresses, ALU
//          control and instruction class flags.
// Ports:   ir (in, 16) instruction; rf_raddr_a/b (out, 4); alu_op (out, 4);
//          alu_eq (out); alu_ltgt (out, 3); writes_rd, is_branch, is_halt (out).
module alu_issue_decode
  import alu_issue_pkg::*;
#(
  parameter logic [3:0] C1_ADDR = 4'd1,
  parameter logic [3:0] C2_ADDR = 4'd2
) (
  input  logic [15:0] ir,
  output logic [3:0]  rf_raddr_a,
  output logic [3:0]  rf_raddr_b,
  output logic [3:0]  alu_op,
  output logic        alu_eq,
  output logic [2:0]  alu_ltgt,
  output logic        writes_rd,
  output logic        is_branch,
  output logic        is_halt
);

  logic [3:0] opc;
  assign opc = ir[OPC_LSB +: 4];

  always_comb begin
    rf_raddr_a = 4'd0;
    rf_raddr_b = 4'd0;
    alu_op     = ALU_OP_ADD;
    alu_eq     = 1'b0;
    alu_ltgt   = LTGT_EQ;
    writes_rd  = 1'b0;
    is_branch  = 1'b0;
    is_halt    = 1'b0;
    case (opc)
      OPC_ADD: begin
        rf_raddr_a = ir[RA_LSB +: 4];
        rf_raddr_b = ir[RB_LSB +: 4];
        alu_eq     = 1'b1;
        writes_rd  = 1'b1;
      end
      OPC_SUB: begin
        rf_raddr_a = ir[RA_LSB +: 4];
        rf_raddr_b = ir[RB_LSB +: 4];
        writes_rd  = 1'b1;
      end
      OPC_EPAR: begin
        rf_raddr_a = ir[RA_LSB +: 4];
        rf_raddr_b = ir[RB_LSB +: 4];
        alu_op     = ALU_OP_EPAR;
        writes_rd  = 1'b1;
      end
      OPC_BR: begin
        // Branches always compare the two fixed compare registers
        rf_raddr_a = C1_ADDR;
        rf_raddr_b = C2_ADDR;
        alu_op     = ALU_OP_BR;
        alu_eq     = ir[BR_EQ_BIT];
        alu_ltgt   = {1'b0, ir[BR_LTGT_LSB +: 2]};
        is_branch  = 1'b1;
      end
      OPC_HALT: is_halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - fetch/decode/issue sequencer for the ALU control path
// Purpose: fetches 16-bit instructions, issues them to regfile and ALU over
//          four cycles, writes back results and advances or branches the PC.
// Ports:   clock, reset (async, active-high); bus (alu_issue_if.master):
//          imem req/addr/ack/data, rf read/write ports, ALU control/results;
//          pc (out, PC_W); halted (out); br_taken_cnt (out, 16).
// Config:  ALU_ISSUE_BRCNT_EN enables the saturating taken-branch counter;
//          otherwise br_taken_cnt is tied to zero.
module alu_issue_seq
  import alu_issue_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      C1_ADDR  = 4'd1,
  parameter logic [3:0]      C2_ADDR  = 4'd2
) (
  input  logic            clock,
  input  logic            reset,
  alu_issue_if.master     bus,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic [15:0]     br_taken_cnt
);

  state_t          state, state_nx;
  logic [PC_W-1:0] pc_q, pc_nx;
  logic [15:0]     ir_q;
  logic [15:0]     alu_out_q;
  logic            compres_q;

  logic [3:0] dec_raddr_a, dec_raddr_b, dec_op;
  logic       dec_eq, dec_wr, dec_br, dec_halt;
  logic [2:0] dec_ltgt;
  logic       taken;

  alu_issue_decode #(
    .C1_ADDR (C1_ADDR),
    .C2_ADDR (C2_ADDR)
  ) u_decode (
    .ir         (ir_q),
    .rf_raddr_a (dec_raddr_a),
    .rf_raddr_b (dec_raddr_b),
    .alu_op     (dec_op),
    .alu_eq     (dec_eq),
    .alu_ltgt   (dec_ltgt),
    .writes_rd  (dec_wr),
    .is_branch  (dec_br),
    .is_halt    (dec_halt)
  );

  // ltgt==3 is the "never" compare: the ALU result is disregarded
  assign taken = dec_br && compres_q && (ir_q[BR_LTGT_LSB +: 2] != LTGT_NEVER);

  // Offset is sign-extended past PC_W so the add wraps modulo 2^PC_W
  logic [PC_W+BR_OFF_W-1:0] off_ext, br_sum;
  assign off_ext = {{PC_W{ir_q[BR_OFF_W-1]}}, ir_q[BR_OFF_W-1:0]};
  assign br_sum  = {{BR_OFF_W{1'b0}}, pc_q} + off_ext;
  assign pc_nx   = taken ? br_sum[PC_W-1:0] : pc_q + PC_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pc_q      <= RESET_PC;
      ir_q      <= 16'h0000;
      alu_out_q <= 16'h0000;
      compres_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_FETCH && bus.imem_ack) ir_q <= bus.imem_data;
      if (state == ST_EXEC) begin
        alu_out_q <= bus.alu_out;
        compres_q <= bus.alu_compres;
      end
      if (state == ST_WB) pc_q <= pc_nx;
    end
  end

  always_comb begin
    state_nx       = state;
    bus.imem_req   = 1'b0;
    bus.imem_addr  = '0;
    bus.rf_raddr_a = 4'd0;
    bus.rf_raddr_b = 4'd0;
    bus.alu_op     = 4'd0;
    bus.alu_eq     = 1'b0;
    bus.alu_ltgt   = 3'd0;
    bus.rf_we      = 1'b0;
    bus.rf_waddr   = 4'd0;
    bus.rf_wdata   = 16'h0000;
    case (state)
      ST_IDLE: state_nx = ST_FETCH;
      ST_FETCH: begin
        bus.imem_req  = 1'b1;
        bus.imem_addr = pc_q;
        if (bus.imem_ack) state_nx = ST_DECODE;
      end
      ST_DECODE, ST_EXEC: begin
        // Control held across both cycles so the ALU sees a stable setup
        bus.rf_raddr_a = dec_raddr_a;
        bus.rf_raddr_b = dec_raddr_b;
        bus.alu_op     = dec_op;
        bus.alu_eq     = dec_eq;
        bus.alu_ltgt   = dec_ltgt;
        if (state == ST_DECODE) state_nx = dec_halt ? ST_HALT : ST_EXEC;
        else                    state_nx = ST_WB;
      end
      ST_WB: begin
        bus.rf_we = dec_wr;
        if (dec_wr) begin
          bus.rf_waddr = ir_q[RD_LSB +: 4];
          bus.rf_wdata = alu_out_q;
        end
        state_nx = ST_FETCH;
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign pc     = pc_q;
  assign halted = (state == ST_HALT);

`ifdef ALU_ISSUE_BRCNT_EN
  logic [15:0] br_cnt_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) br_cnt_q <= 16'h0000;
    else if (state == ST_WB && taken && br_cnt_q != 16'hFFFF) br_cnt_q <= br_cnt_q + 16'd1;
  end
  assign br_taken_cnt = br_cnt_q;
`else
  assign br_taken_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - self-checking bench for alu_issue_seq
module tb_alu_issue_seq;
  localparam int PC_W = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [PC_W-1:0] pc;
  logic            halted;
  logic [15:0]     br_taken_cnt;

  alu_issue_if #(.PC_W(PC_W)) bus ();

  alu_issue_seq #(.PC_W(PC_W)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.master),
    .pc           (pc),
    .halted       (halted),
    .br_taken_cnt (br_taken_cnt)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int m_pc     = 0;
  int m_cnt    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  function automatic int exp_cnt();
`ifdef ALU_ISSUE_BRCNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic noise;
    bus.imem_ack  = 1'($urandom_range(0, 1));
    bus.imem_data = 16'($urandom);
  endtask

  // Called in a FETCH cycle; returns in the next FETCH cycle
  task automatic exec_one(input logic [15:0] instr, input logic [15:0] aout,
                          input logic cres, input int waits);
    int opc, e_a, e_b, e_op, e_eq, e_lt, off;
    bit known, kb, e_we, taken;
    opc = int'(instr[15:12]);
    known = 1; kb = 1; e_we = 0; e_lt = 0; e_a = 0; e_b = 0; e_op = 0; e_eq = 0;
    case (opc)
      0: begin e_op = 0; e_eq = 1; e_a = int'(instr[7:4]); e_b = int'(instr[3:0]); e_we = 1; end
      1: begin e_op = 0; e_eq = 0; e_a = int'(instr[7:4]); e_b = int'(instr[3:0]); e_we = 1; end
      5: begin e_op = 5; e_eq = 0; e_a = int'(instr[7:4]); kb = 0; e_we = 1; end
      4: begin e_op = 4; e_eq = int'(instr[11]); e_lt = int'(instr[10:9]); e_a = 1; e_b = 2; end
      default: known = 0;
    endcase
    bus.alu_out = aout;
    bus.alu_compres = cres;
    check("fetch_req", bus.imem_req, 1);
    check("fetch_addr", bus.imem_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      bus.imem_ack = 1'b0;
      bus.imem_data = 16'($urandom);
      step;
      check("wait_req", bus.imem_req, 1);
      check("wait_pc", pc, m_pc);
    end
    bus.imem_ack = 1'b1;
    bus.imem_data = instr;
    step;
    noise;
    check("dec_req", bus.imem_req, 0);
    if (opc == 15) return;
    for (int s = 0; s < 2; s++) begin
      if (known) begin
        check(s == 0 ? "dec_op" : "exe_op", bus.alu_op, e_op);
        check(s == 0 ? "dec_eq" : "exe_eq", bus.alu_eq, e_eq);
        check(s == 0 ? "dec_ra" : "exe_ra", bus.rf_raddr_a, e_a);
        if (kb) check(s == 0 ? "dec_rb" : "exe_rb", bus.rf_raddr_b, e_b);
        if (opc == 4) check(s == 0 ? "dec_ltgt" : "exe_ltgt", bus.alu_ltgt, e_lt);
      end
      check("no_we", bus.rf_we, 0);
      step;
      noise;
    end
    bus.alu_out = ~aout;
    bus.alu_compres = ~cres;
    check("wb_we", bus.rf_we, e_we);
    if (e_we) begin
      check("wb_waddr", bus.rf_waddr, int'(instr[11:8]));
      check("wb_wdata", bus.rf_wdata, aout);
    end
    check("wb_op_zero", bus.alu_op, 0);
    check("wb_req", bus.imem_req, 0);
    off = instr[8] ? int'(instr[8:0]) - 512 : int'(instr[8:0]);
    taken = (opc == 4) && cres && (instr[10:9] != 2'd3);
    m_pc = taken ? ((m_pc + off) & 255) : ((m_pc + 1) & 255);
    if (taken && m_cnt < 65535) m_cnt++;
    step;
    bus.imem_ack = 1'b0;
    check("next_pc", pc, m_pc);
    check("next_req", bus.imem_req, 1);
    check("br_cnt", br_taken_cnt, exp_cnt());
  endtask

  function automatic logic [15:0] rand_instr();
    int k;
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 4))
      0: w[15:12] = 4'd0;
      1: w[15:12] = 4'd1;
      2: w[15:12] = 4'd5;
      3: w[15:12] = 4'd4;
      default: begin
        k = $urandom_range(0, 10);
        w[15:12] = 4'(k < 2 ? k + 2 : k + 4);
      end
    endcase
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [15:0] ins;
    bus.imem_ack = 1'b1;
    bus.imem_data = 16'h0312;
    bus.alu_out = 16'h0;
    bus.alu_compres = 1'b0;
    repeat (3) step;
    check("rst_req", bus.imem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_halted", halted, 0);
    check("rst_we", bus.rf_we, 0);
    check("rst_cnt", br_taken_cnt, 0);
    reset = 1'b0;
    check("idle_req", bus.imem_req, 0);
    step;

    exec_one(16'h0312, 16'h0007, 1'b0, 0);
    exec_one(16'h1312, 16'($urandom), 1'b0, 0);
    exec_one(16'h5410, 16'h0001, 1'b0, 0);
    while (m_pc != 10) exec_one(16'h2000, 16'($urandom), 1'b1, 0);
    exec_one(16'h4A05, 16'($urandom), 1'b1, 0);
    exec_one(16'h4BFB, 16'($urandom), 1'b1, 0);
    exec_one(16'h4A05, 16'($urandom), 1'b0, 0);
    exec_one(16'h4BFF, 16'($urandom), 1'b1, 0);
    exec_one(16'h4BFF, 16'($urandom), 1'b1, 0);
    check("br_back_pc", pc, 9);
    exec_one(16'h4E05, 16'($urandom), 1'b1, 0);
    exec_one(16'h3000, 16'($urandom), 1'b0, 3);
    ins = 16'h4200 | 16'(255 - m_pc);
    exec_one(ins, 16'($urandom), 1'b1, 1);
    check("pc_max", pc, 255);
    exec_one(16'h7000, 16'($urandom), 1'b0, 0);
    check("pc_wrap", pc, 0);

    for (int n = 0; n < 120; n++)
      exec_one(rand_instr(), 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3));

    // Reset during EXEC of an ADD
    while (m_pc == 0) exec_one(16'h2000, 16'h0, 1'b0, 0);
    bus.imem_ack = 1'b1;
    bus.imem_data = 16'h0312;
    step;
    noise;
    step;
    reset = 1'b1;
    #1;
    check("arst_pc", pc, 0);
    check("arst_op", bus.alu_op, 0);
    check("arst_eq", bus.alu_eq, 0);
    check("arst_ra", bus.rf_raddr_a, 0);
    check("arst_req", bus.imem_req, 0);
    check("arst_cnt", br_taken_cnt, 0);
    m_pc = 0;
    m_cnt = 0;
    #2;
    reset = 1'b0;
    bus.imem_ack = 1'b0;
    step;
    check("refetch_addr", bus.imem_addr, 0);

    exec_one(16'h4A05, 16'h0, 1'b1, 0);
    exec_one(16'h4A05, 16'h0, 1'b0, 1);
    exec_one(16'h4403, 16'h0, 1'b1, 0);
    exec_one(16'h4E01, 16'h0, 1'b1, 2);
    exec_one(16'h4202, 16'h0, 1'b1, 0);
    check("cnt_3_taken", br_taken_cnt, exp_cnt());
`ifdef ALU_ISSUE_BRCNT_EN
    check("cnt_value", br_taken_cnt, 3);
`else
    check("cnt_tied", br_taken_cnt, 0);
`endif

    exec_one(16'hF000, 16'h0, 1'b0, 0);
    step;
    check("halted", halted, 1);
    for (int i = 0; i < 20; i++) begin
      noise;
      step;
      check("halt_req", bus.imem_req, 0);
      check("halt_stay", halted, 1);
      check("halt_pc", pc, m_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
